// File: rtl/candidate_generator.sv
// candidate_generator
//   Brute-force candidate source. Enumerates every string over a CHARSET_SIZE
//   alphabet as a mixed-radix odometer (rightmost used position is the least
//   significant digit) and presents one candidate per accepted transfer on a
//   valid/ready stream feeding the hash core's message-load stage.
//
//   Optional feature macro: CANDGEN_LEN_SWEEP_EN
//     defined   : lengths min_len..max_len are enumerated in ascending order
//     undefined : only length max_len (clamped) is generated, min_len ignored
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            one-cycle pulse, (re)starts enumeration, wins over accept
//   min_len/max_len  length bounds, sampled on start and clamped to 1..MAX_LEN
//   out_ready        consumer accepts candidate
//   out_valid        out_chars/out_len/out_last are valid
//   out_chars        candidate, position 0 in the top CHAR_W bits, unused
//                    positions zero
//   out_len          length of presented candidate
//   out_last         presented candidate is the final one of the run
//   busy             enumeration in progress
//   exhausted        keyspace finished, sticky until start/reset
module candidate_generator #(
  parameter int MAX_LEN      = 16,
  parameter int CHARSET_SIZE = 62,
  parameter int CHAR_W       = 8,
  localparam int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LW-1:0]             min_len,
  input  logic [LW-1:0]             max_len,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [MAX_LEN*CHAR_W-1:0] out_chars,
  output logic [LW-1:0]             out_len,
  output logic                      out_last,
  output logic                      busy,
  output logic                      exhausted
);

  localparam int IW = (CHARSET_SIZE > 2) ? $clog2(CHARSET_SIZE) : 1;
  localparam logic [IW-1:0] TOP = IW'(CHARSET_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                         state_q, state_d;
  logic [MAX_LEN-1:0][IW-1:0]     dig_q, dig_d;
  logic [LW-1:0]                  len_q, len_d, max_q, max_d;
  logic                           valid_q, valid_d, last_q, last_d;
  logic                           busy_q, busy_d, exh_q, exh_d;
  logic [MAX_LEN-1:0][CHAR_W-1:0] chars_q, chars_d;
  logic [LW-1:0]                  lo, hi;
  logic                           carry;

  // index -> ASCII: digits, lower, upper, then remaining printables ascending
  function automatic logic [7:0] char_rom(input int idx);
    int c;
    if      (idx < 10) c = 48  + idx;
    else if (idx < 36) c = 97  + idx - 10;
    else if (idx < 62) c = 65  + idx - 36;
    else if (idx < 78) c = 32  + idx - 62;   // ' '..'/'
    else if (idx < 85) c = 58  + idx - 78;   // ':'..'@'
    else if (idx < 91) c = 91  + idx - 85;   // '['..'`'
    else               c = 123 + idx - 91;   // '{'..'~'
    return 8'(c);
  endfunction

  // every used digit at its top symbol -> final candidate of this length
  function automatic logic all_top(input logic [MAX_LEN-1:0][IW-1:0] d,
                                   input logic [LW-1:0] l);
    all_top = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < l && d[i] != TOP) all_top = 1'b0;
  endfunction

  // Length clamping. A zero max is also lifted to 1 so an empty string is
  // never produced as a candidate.
  always_comb begin
    hi = max_len;
    if (max_len > LW'(MAX_LEN)) hi = LW'(MAX_LEN);
    else if (max_len == '0)     hi = LW'(1);
`ifdef CANDGEN_LEN_SWEEP_EN
    lo = (min_len == '0) ? LW'(1) : min_len;
    if (lo > hi) lo = hi;
`else
    lo = hi;
`endif
  end

`ifndef CANDGEN_LEN_SWEEP_EN
  logic unused_min;
  assign unused_min = ^min_len;
`endif

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    len_d   = len_q;
    max_d   = max_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    exh_d   = exh_q;
    carry   = 1'b0;
    if (start) begin
      state_d = RUN;
      dig_d   = '0;
      len_d   = lo;
      max_d   = hi;
      valid_d = 1'b1;
      busy_d  = 1'b1;
      exh_d   = 1'b0;
    end else if (state_q == RUN && valid_q && out_ready) begin
      if (last_q) begin
        state_d = DONE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        exh_d   = 1'b1;
      end
`ifdef CANDGEN_LEN_SWEEP_EN
      else if (all_top(dig_q, len_q)) begin
        len_d = len_q + 1'b1;
        dig_d = '0;
      end
`endif
      else begin
        // ripple carry from the LSD (position len-1) towards position 0
        carry = 1'b1;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
          if (LW'(i) < len_q && carry) begin
            if (dig_q[i] == TOP) dig_d[i] = '0;
            else begin
              dig_d[i] = dig_q[i] + 1'b1;
              carry    = 1'b0;
            end
          end
        end
      end
    end
    last_d = valid_d && all_top(dig_d, len_d) && (len_d == max_d);
  end

  // position p lands in chars_d[MAX_LEN-1-p] so position 0 is the top byte
  for (genvar p = 0; p < MAX_LEN; p++) begin : g_pos
    assign chars_d[MAX_LEN-1-p] = (LW'(p) < len_d)
                                  ? CHAR_W'(char_rom(int'(dig_d[p]))) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dig_q   <= '0;
      len_q   <= '0;
      max_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      exh_q   <= 1'b0;
      chars_q <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      len_q   <= len_d;
      max_q   <= max_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      exh_q   <= exh_d;
      chars_q <= chars_d;
    end
  end

  assign out_valid = valid_q;
  assign out_chars = chars_q;
  assign out_len   = len_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign exhausted = exh_q;

endmodule
